// File: rtl/lcd_img_ctrl_if.sv
// Command, IROM and IRAM signal bundle of the LCD image controller.
// The slave modport is the controller; the master modport is the tester and memory side.
interface lcd_img_ctrl_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 6
);
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic          IROM_rd;
   logic [AW-1:0] IROM_A;
   logic [DW-1:0] IROM_Q;
   logic          IRAM_valid;
   logic [DW-1:0] IRAM_D;
   logic [AW-1:0] IRAM_A;
   logic          busy;
   logic          done;

   modport master (
      output cmd, cmd_valid, IROM_Q,
      input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
   );

   modport slave (
      input  cmd, cmd_valid, IROM_Q,
      output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
   );
endinterface

// File: rtl/lcd_img_ctrl.sv
// LCD image controller: loads an IMG_W x IMG_W image from IROM, runs 2x2 window commands, writes to IRAM.
// Optional feature: define LCD_CTRL_CLEAR_EN to make command C clear the window to zero.
module lcd_img_ctrl #(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 6
) (
   input logic           clk,
   input logic           reset,
   lcd_img_ctrl_if.slave bus
);

   localparam int unsigned   CW   = $clog2(IMG_W);
   localparam int unsigned   NPIX = IMG_W * IMG_W;
   localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
   localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
   localparam logic [CW-1:0] CMID = CW'(IMG_W / 2);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [2:0] {StLoad, StIdle, StExec, StWrite, StDone} state_e;

   state_e        state_q;
   logic [3:0]    cmd_q;
   logic [CW-1:0] x_q, y_q;
   logic          ld_pend_q;
   logic [AW-1:0] ld_addr_q;

   logic [DW-1:0] img [NPIX];

   logic [CW-1:0] xm1, ym1;
   logic [AW-1:0] i_tl, i_tr, i_bl, i_br;
   logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
   logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
   logic [DW-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn;
   logic [DW+1:0] sum;
   logic          win_we;

   // Power-of-two width makes row*IMG_W+col a plain concatenation.
   assign xm1  = x_q - ONE;
   assign ym1  = y_q - ONE;
   assign i_tl = {ym1, xm1};
   assign i_tr = {ym1, x_q};
   assign i_bl = {y_q, xm1};
   assign i_br = {y_q, x_q};

   assign p_tl = img[i_tl];
   assign p_tr = img[i_tr];
   assign p_bl = img[i_bl];
   assign p_br = img[i_br];

   assign mx_t = (p_tl > p_tr) ? p_tl : p_tr;
   assign mx_b = (p_bl > p_br) ? p_bl : p_br;
   assign mx   = (mx_t > mx_b) ? mx_t : mx_b;
   assign mn_t = (p_tl < p_tr) ? p_tl : p_tr;
   assign mn_b = (p_bl < p_br) ? p_bl : p_br;
   assign mn   = (mn_t < mn_b) ? mn_t : mn_b;
   assign sum  = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};

   always_comb begin
      n_tl   = p_tl;
      n_tr   = p_tr;
      n_bl   = p_bl;
      n_br   = p_br;
      win_we = 1'b0;
      if (state_q == StExec) begin
         case (cmd_q)
            4'h5: begin win_we = 1'b1; n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
            4'h6: begin win_we = 1'b1; n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
            4'h7: begin
               win_we = 1'b1;
               n_tl = sum[DW+1:2]; n_tr = sum[DW+1:2];
               n_bl = sum[DW+1:2]; n_br = sum[DW+1:2];
            end
            4'h8: begin win_we = 1'b1; n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
            4'h9: begin win_we = 1'b1; n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
            4'hA: begin win_we = 1'b1; n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
            4'hB: begin win_we = 1'b1; n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
`ifdef LCD_CTRL_CLEAR_EN
            4'hC: begin win_we = 1'b1; n_tl = '0; n_tr = '0; n_bl = '0; n_br = '0; end
`endif
            default: ;
         endcase
      end
   end

   // Pixel buffer carries no reset; it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (ld_pend_q) begin
         img[ld_addr_q] <= bus.IROM_Q;
      end else if (win_we) begin
         img[i_tl] <= n_tl;
         img[i_tr] <= n_tr;
         img[i_bl] <= n_bl;
         img[i_br] <= n_br;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StLoad;
         cmd_q          <= 4'h0;
         x_q            <= CMID;
         y_q            <= CMID;
         ld_pend_q      <= 1'b0;
         ld_addr_q      <= '0;
         bus.IROM_rd    <= 1'b0;
         bus.IROM_A     <= '0;
         bus.IRAM_valid <= 1'b0;
         bus.IRAM_D     <= '0;
         bus.IRAM_A     <= '0;
         bus.busy       <= 1'b1;
         bus.done       <= 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               // Start reading once, right after reset; IROM_A parks at LAST afterwards.
               if (!bus.IROM_rd && !ld_pend_q && bus.IROM_A == '0) bus.IROM_rd <= 1'b1;
               if (bus.IROM_rd) begin
                  ld_pend_q <= 1'b1;
                  ld_addr_q <= bus.IROM_A;
                  if (bus.IROM_A == LAST) bus.IROM_rd <= 1'b0;
                  else                    bus.IROM_A  <= bus.IROM_A + AW'(1);
               end else begin
                  ld_pend_q <= 1'b0;
               end
               if (ld_pend_q && ld_addr_q == LAST) begin
                  state_q  <= StIdle;
                  bus.busy <= 1'b0;
               end
            end
            StIdle: begin
               if (bus.cmd_valid && !bus.busy) begin
                  cmd_q    <= bus.cmd;
                  bus.busy <= 1'b1;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               case (cmd_q)
                  4'h0: begin
                     state_q        <= StWrite;
                     bus.IRAM_valid <= 1'b1;
                     bus.IRAM_A     <= '0;
                     bus.IRAM_D     <= img[0];
                  end
                  4'h1: if (y_q > ONE)  y_q <= y_q - ONE;
                  4'h2: if (y_q < CMAX) y_q <= y_q + ONE;
                  4'h3: if (x_q > ONE)  x_q <= x_q - ONE;
                  4'h4: if (x_q < CMAX) x_q <= x_q + ONE;
                  default: ;
               endcase
               if (cmd_q != 4'h0) begin
                  bus.busy <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StWrite: begin
               if (bus.IRAM_A == LAST) begin
                  bus.IRAM_valid <= 1'b0;
                  bus.done       <= 1'b1;
                  state_q        <= StDone;
               end else begin
                  bus.IRAM_A <= bus.IRAM_A + AW'(1);
                  bus.IRAM_D <= img[bus.IRAM_A + AW'(1)];
               end
            end
            StDone: ;
            default: state_q <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_img_ctrl.sv
// Self-checking bench for lcd_img_ctrl: reference image model plus IRAM write-out scoreboard.
module tb_lcd_img_ctrl;

   localparam int W = 8;
   localparam int N = W * W;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lcd_img_ctrl_if #(.DW(8), .AW(6)) bus ();

   lcd_img_ctrl #(.IMG_W(W), .DW(8), .AW(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] irom [N];
   int         ref_img [N];
   int         rx, ry;
   wr_t        sb [$];
   int         pass_cnt = 0;
   int         total_cnt = 0;

   always @(posedge clk) if (bus.IROM_rd) bus.IROM_Q <= irom[bus.IROM_A];

   // Scoreboard consumer: every IRAM write must match the next expected pixel.
   always @(negedge clk) begin
      if (!reset && bus.IRAM_valid) begin
         total_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL iram_extra: got write A=%0d D=%0d, required none", bus.IRAM_A, bus.IRAM_D);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (int'(bus.IRAM_A) !== e.addr || int'(bus.IRAM_D) !== e.data)
               $display("FAIL iram_write: got A=%0d D=%0d, required A=%0d D=%0d",
                        bus.IRAM_A, bus.IRAM_D, e.addr, e.data);
            else pass_cnt++;
         end
      end
   end

   task automatic model_cmd(input logic [3:0] c);
      int tl, tr, bl, br, a, b, cc, d, m;
      tl = (ry - 1) * W + rx - 1; tr = tl + 1; bl = tl + W; br = bl + 1;
      a = ref_img[tl]; b = ref_img[tr]; cc = ref_img[bl]; d = ref_img[br];
      case (c)
         4'h1: if (ry > 1) ry--;
         4'h2: if (ry < W - 1) ry++;
         4'h3: if (rx > 1) rx--;
         4'h4: if (rx < W - 1) rx++;
         4'h5: begin
            m = a; if (b > m) m = b; if (cc > m) m = cc; if (d > m) m = d;
            ref_img[tl] = m; ref_img[tr] = m; ref_img[bl] = m; ref_img[br] = m;
         end
         4'h6: begin
            m = a; if (b < m) m = b; if (cc < m) m = cc; if (d < m) m = d;
            ref_img[tl] = m; ref_img[tr] = m; ref_img[bl] = m; ref_img[br] = m;
         end
         4'h7: begin
            m = (a + b + cc + d) / 4;
            ref_img[tl] = m; ref_img[tr] = m; ref_img[bl] = m; ref_img[br] = m;
         end
         4'h8: begin ref_img[tl] = b; ref_img[tr] = d; ref_img[br] = cc; ref_img[bl] = a; end
         4'h9: begin ref_img[tl] = cc; ref_img[bl] = d; ref_img[br] = b; ref_img[tr] = a; end
         4'hA: begin ref_img[tl] = cc; ref_img[bl] = a; ref_img[tr] = d; ref_img[br] = b; end
         4'hB: begin ref_img[tl] = b; ref_img[tr] = a; ref_img[bl] = d; ref_img[br] = cc; end
`ifdef LCD_CTRL_CLEAR_EN
         4'hC: begin ref_img[tl] = 0; ref_img[tr] = 0; ref_img[bl] = 0; ref_img[br] = 0; end
`endif
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) ref_img[i] = int'(irom[i]);
      rx = W / 2;
      ry = W / 2;
      sb.delete();
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== 1'b0) begin
         total_cnt++;
         $display("FAIL ready_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
      end
   endtask

   task automatic send_cmd(input logic [3:0] c);
      wait_ready();
      bus.cmd       = c;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (c == 4'h0) begin
         for (int i = 0; i < N; i++) sb.push_back('{addr: i, data: ref_img[i]});
      end else begin
         model_cmd(c);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (bus.done !== 1'b1) $display("FAIL done_timeout: done=%b, required 1", bus.done);
      else pass_cnt++;
   endtask

   task automatic finish_write(input string name);
      send_cmd(4'h0);
      wait_done();
      repeat (3) @(negedge clk);
      total_cnt++;
      if (sb.size() !== 0 || bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.IRAM_valid !== 1'b0)
         $display("FAIL %s_end: left=%0d done=%b busy=%b valid=%b, required 0 1 1 0",
                  name, sb.size(), bus.done, bus.busy, bus.IRAM_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) irom[i] = 8'(i);
      reset = 1'b1;
      bus.cmd = 4'h0;
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.IROM_rd !== 1'b0 || bus.IROM_A !== 6'd0 ||
          bus.IRAM_valid !== 1'b0 || bus.IRAM_D !== 8'd0 || bus.IRAM_A !== 6'd0)
         $display("FAIL reset_values: busy=%b done=%b rd=%b IROM_A=%0d valid=%b D=%0d IRAM_A=%0d, required 1 0 0 0 0 0 0",
                  bus.busy, bus.done, bus.IROM_rd, bus.IROM_A, bus.IRAM_valid, bus.IRAM_D, bus.IRAM_A);
      else pass_cnt++;
   endtask

   task automatic test_load();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total_cnt++;
         if (bus.IROM_rd !== 1'b1 || int'(bus.IROM_A) !== k)
            $display("FAIL load_addr: rd=%b A=%0d, required rd=1 A=%0d", bus.IROM_rd, bus.IROM_A, k);
         else pass_cnt++;
      end
      finish_write("load");
   endtask

   task automatic test_window_ops();
      logic [3:0] ops [4] = '{4'h5, 4'h7, 4'h8, 4'hA};
      for (int k = 0; k < 4; k++) begin
         do_reset();
         send_cmd(ops[k]);
         finish_write("window_op");
      end
      do_reset();
      send_cmd(4'h9);
      send_cmd(4'hB);
      send_cmd(4'h6);
      finish_write("rot_cw_mirror_y");
   endtask

   task automatic test_boundary();
      do_reset();
      repeat (5) send_cmd(4'h3);
      send_cmd(4'h6);
      repeat (5) send_cmd(4'h1);
      send_cmd(4'h8);
      repeat (9) send_cmd(4'h2);
      repeat (9) send_cmd(4'h4);
      send_cmd(4'h5);
      finish_write("boundary");
   endtask

   task automatic test_handshake();
      do_reset();
      wait_ready();
      bus.cmd       = 4'h4;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL accept_busy: busy=%b, required 1", bus.busy);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL ready_latency: busy=%b, required 0", bus.busy);
      else pass_cnt++;
      bus.cmd_valid = 1'b0;
      model_cmd(4'h4);
      send_cmd(4'h5);
      finish_write("handshake");
   endtask

   task automatic test_reset_mid_write();
      int n;
      do_reset();
      send_cmd(4'h0);
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         if (bus.IRAM_valid === 1'b1) n++;
         else if (bus.done === 1'b1) n = 10;
      end
      for (int i = 0; i < N; i++) irom[i] = 8'($urandom);
      #2 reset = 1'b1;
      #1;
      total_cnt++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.IROM_rd !== 1'b0 || bus.IROM_A !== 6'd0 ||
          bus.IRAM_valid !== 1'b0 || bus.IRAM_D !== 8'd0 || bus.IRAM_A !== 6'd0)
         $display("FAIL abort_values: busy=%b done=%b rd=%b IROM_A=%0d valid=%b D=%0d IRAM_A=%0d, required 1 0 0 0 0 0 0",
                  bus.busy, bus.done, bus.IROM_rd, bus.IROM_A, bus.IRAM_valid, bus.IRAM_D, bus.IRAM_A);
      else pass_cnt++;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) ref_img[i] = int'(irom[i]);
      rx = W / 2;
      ry = W / 2;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total_cnt++;
         if (bus.IROM_rd !== 1'b1 || int'(bus.IROM_A) !== k)
            $display("FAIL reload_addr: rd=%b A=%0d, required rd=1 A=%0d", bus.IROM_rd, bus.IROM_A, k);
         else pass_cnt++;
      end
      send_cmd(4'h7);
      send_cmd(4'h1);
      send_cmd(4'h9);
      finish_write("reload");
   endtask

   task automatic test_cmd_c();
      do_reset();
      send_cmd(4'hC);
      send_cmd(4'hD);
      send_cmd(4'hF);
      finish_write("cmd_c");
   endtask

   task automatic test_random();
      for (int i = 0; i < N; i++) irom[i] = 8'($urandom);
      do_reset();
      for (int k = 0; k < 40; k++) send_cmd(4'($urandom_range(1, 15)));
      finish_write("random");
   endtask

   initial begin
      test_reset();
      test_load();
      test_window_ops();
      test_boundary();
      test_handshake();
      test_reset_mid_write();
      test_cmd_c();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
